shaft_sensor_emulator: RTL and testbench
========================================

SHAFT_SENSOR_EMULATOR -- requirements
Module: shaft_sensor_emulator

Interface
REQ-001 Parameter TICKS_PER_FLOOR, default 25000, means CCLK cycles of travel between adjacent floors (legal range 4..2^24-1).
REQ-002 Parameter ZONE_TICKS, default 2500, means half-width in cycles of each floor sensor's active zone (legal range 1..TICKS_PER_FLOOR/2-1).
REQ-003 Parameter RESET_FLOOR, default 0, means the floor index 0..3 loaded at reset.
REQ-004 Parameter START_DELAY, default 1000, means cycles a motion command must be stable before travel begins (used only with SHAFT_INERTIA_EN).
REQ-005 CCLK  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 motor  input  2  drive command: 00 stop, 01 up, 10 down, 11 brake (treated as stop).
REQ-008 s4, s3, s2, s1  output  1 each  floor sensors for floors 4..1; s1 = lowest floor (index 0).
REQ-009 floor  output  2  index of the last floor passed or occupied (0..3).
REQ-010 moving  output  1  high in any cycle where the position changes.
REQ-011 limit_fault  output  1  sticky flag for an overtravel attempt.

Function
REQ-012 Position SHALL be held as floor (2 bits) plus sub_cnt (0..TICKS_PER_FLOOR-1), with absolute position floor*TICKS_PER_FLOOR+sub_cnt.
REQ-013 States SHALL be IDLE, UP, DOWN and LIMIT; IDLE->UP on motor=01, IDLE->DOWN on motor=10, UP/DOWN->IDLE on motor=00 or 11, UP<->DOWN directly on a reversed command.
REQ-014 In UP, each cycle: if sub_cnt=TICKS_PER_FLOOR-1, then sub_cnt<=0 and floor<=floor+1; otherwise sub_cnt<=sub_cnt+1.
REQ-015 In DOWN, each cycle: if sub_cnt=0, then floor<=floor-1 and sub_cnt<=TICKS_PER_FLOOR-1; otherwise sub_cnt<=sub_cnt-1.
REQ-016 UP at floor=3 with sub_cnt=0 SHALL NOT move; it SHALL enter LIMIT and set limit_fault on the same edge.
REQ-017 DOWN at floor=0 with sub_cnt=0 SHALL NOT move; it SHALL enter LIMIT and set limit_fault.
REQ-018 Floor and sub_cnt SHALL never wrap past 3 or below 0.
REQ-019 LIMIT SHALL hold position; motor=00/11 returns to IDLE, and a command away from the limit enters UP or DOWN; limit_fault stays 1 until reset.
REQ-020 Sensor for floor k (index k) SHALL be a combinational decode of registered position: active when (floor=k and sub_cnt<ZONE_TICKS) or (floor=k-1 and sub_cnt>=TICKS_PER_FLOOR-ZONE_TICKS).
REQ-021 At most one sensor SHALL be active in any cycle; no sensor is active between zones.
REQ-022 moving SHALL be registered and equal 1 exactly on cycles following an edge where the position changed.
REQ-023 A motor change SHALL take effect on the next rising edge (one-cycle latency) when SHAFT_INERTIA_EN is undefined.

Reset
REQ-024 While rst=1, independently of CCLK: floor=RESET_FLOOR, sub_cnt=0, state=IDLE, moving=0, limit_fault=0, inertia counter=0.
REQ-025 Sensor outputs SHALL therefore show only s(RESET_FLOOR+1)=1 during and after reset.
REQ-026 Reset asserted mid-travel SHALL discard the position immediately; travel resumes from RESET_FLOOR after release.

Configuration
REQ-027 Macro SHAFT_INERTIA_EN defined: a new nonzero command SHALL be applied only after it is stable for START_DELAY consecutive cycles; any change restarts the count; stop/brake acts after one cycle.
REQ-028 Macro SHAFT_INERTIA_EN undefined: the inertia counter SHALL be absent and REQ-023 applies.

Verification (TICKS_PER_FLOOR=8, ZONE_TICKS=2, RESET_FLOOR=0, macro off unless stated)
REQ-029 Release reset, motor=00 -> s1=1, s2..s4=0, floor=0, moving=0, limit_fault=0.
REQ-030 motor=01 for 8 edges -> s1 drops after edge 2, s2 rises after edge 6, floor=1 after edge 8 with s2=1.
REQ-031 At floor 0, sub_cnt=0, motor=10 -> limit_fault=1 after one edge, floor=0, s1 stays 1, moving=0.
REQ-032 Drive up 24 edges to floor 3, then hold motor=01 -> no movement, s4=1, limit_fault=1; motor=10 for 1 edge -> floor=2, sub_cnt=7, s4 still 1.
REQ-033 Mid-travel (floor=1, sub_cnt=4), assert rst asynchronously -> floor=0, s1=1 before the next CCLK edge.
REQ-034 Macro on, START_DELAY=5: motor=01 held 4 cycles then 00 -> no movement; held 5 cycles -> movement starts on the next edge.

Source files
------------

// File: rtl/shaft_sensor_emulator.sv
// Elevator shaft emulator: car position, floor sensors, overtravel flag.
// Optional SHAFT_INERTIA_EN: motion commands must settle before acting.
module shaft_sensor_emulator #(
    parameter int TICKS_PER_FLOOR = 25000,
    parameter int ZONE_TICKS      = 2500,
    parameter int RESET_FLOOR     = 0,
    parameter int START_DELAY     = 1000
) (
    input  logic       CCLK,
    input  logic       rst,
    input  logic [1:0] motor,
    output logic       s4,
    output logic       s3,
    output logic       s2,
    output logic       s1,
    output logic [1:0] floor,
    output logic       moving,
    output logic       limit_fault
);

    localparam int SW = (TICKS_PER_FLOOR > 2) ?
                        $clog2(TICKS_PER_FLOOR) : 1;

    localparam logic [SW-1:0] SUB_TOP = SW'(TICKS_PER_FLOOR - 1);
    localparam logic [SW-1:0] ZONE_LO = SW'(ZONE_TICKS);
    localparam logic [SW-1:0] ZONE_HI =
        SW'(TICKS_PER_FLOOR - ZONE_TICKS);

    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        LIMIT
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] sub_cnt;
    logic [1:0]    cmd;
    logic          step_up;
    logic          step_dn;
    logic          fault_set;
    logic          at_top;
    logic          at_bot;
    logic [3:0]    sens;

`ifdef SHAFT_INERTIA_EN
    localparam int CW = (START_DELAY > 1) ?
                        $clog2(START_DELAY + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(START_DELAY);

    logic [1:0]    motor_q;
    logic [CW-1:0] stable_cnt;
    logic          go;

    assign go = motor[0] ^ motor[1];

    // Count consecutive cycles the same run command has been held.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            motor_q    <= 2'b00;
            stable_cnt <= '0;
        end else begin
            motor_q <= motor;
            if (!go) begin
                stable_cnt <= '0;
            end else if (motor != motor_q) begin
                stable_cnt <= CW'(1);
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    // Run commands only once settled; stop/brake passes straight through.
    always_comb begin
        cmd = 2'b00;
        if (go && motor == motor_q && stable_cnt == CNT_MAX) begin
            cmd = motor;
        end
    end
`else
    logic unused_delay;

    assign unused_delay = (START_DELAY != 0);

    // Without inertia the command acts on the very next edge.
    always_comb begin
        cmd = motor;
    end
`endif

    // Floor 3 is only ever occupied at sub_cnt 0, so the floor alone
    // marks the top; the bottom needs both fields.
    assign at_top = (floor == 2'd3);
    assign at_bot = (floor == 2'd0) && (sub_cnt == '0);

    // Next state and one-cycle movement decision from the command.
    always_comb begin
        state_d   = IDLE;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        fault_set = 1'b0;
        unique case (cmd)
            CMD_UP: begin
                if (at_top) begin
                    state_d   = LIMIT;
                    fault_set = (state_q != LIMIT);
                end else begin
                    state_d = UP;
                    step_up = 1'b1;
                end
            end
            CMD_DOWN: begin
                if (at_bot) begin
                    state_d   = LIMIT;
                    fault_set = (state_q != LIMIT);
                end else begin
                    state_d = DOWN;
                    step_dn = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, position counter and status flags.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            floor       <= 2'(RESET_FLOOR);
            sub_cnt     <= '0;
            moving      <= 1'b0;
            limit_fault <= 1'b0;
        end else begin
            state_q <= state_d;
            moving  <= step_up | step_dn;
            if (fault_set) begin
                limit_fault <= 1'b1;
            end
            if (step_up) begin
                if (sub_cnt == SUB_TOP) begin
                    sub_cnt <= '0;
                    floor   <= floor + 2'd1;
                end else begin
                    sub_cnt <= sub_cnt + SW'(1);
                end
            end else if (step_dn) begin
                if (sub_cnt == '0) begin
                    sub_cnt <= SUB_TOP;
                    floor   <= floor - 2'd1;
                end else begin
                    sub_cnt <= sub_cnt - SW'(1);
                end
            end
        end
    end

    // Sensor k sees the car near floor k from above or below.
    always_comb begin
        sens = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (floor == 2'(k) && sub_cnt < ZONE_LO) begin
                sens[k] = 1'b1;
            end
            if (k > 0 && floor == 2'(k - 1) && sub_cnt >= ZONE_HI) begin
                sens[k] = 1'b1;
            end
        end
    end

    assign s1 = sens[0];
    assign s2 = sens[1];
    assign s3 = sens[2];
    assign s4 = sens[3];

endmodule

// File: tb/tb_shaft_sensor_emulator.sv
// Directed bench for shaft_sensor_emulator (8 ticks/floor, zone 2).
// Expected values are worked out by hand from the position arithmetic.
module tb_shaft_sensor_emulator;

    logic       CCLK;
    logic       rst;
    logic [1:0] motor;
    logic       s4;
    logic       s3;
    logic       s2;
    logic       s1;
    logic [1:0] floor;
    logic       moving;
    logic       limit_fault;

    int checks;
    int failures;

    shaft_sensor_emulator #(
        .TICKS_PER_FLOOR(8),
        .ZONE_TICKS(2),
        .RESET_FLOOR(0),
        .START_DELAY(5)
    ) dut (
        .CCLK(CCLK),
        .rst(rst),
        .motor(motor),
        .s4(s4),
        .s3(s3),
        .s2(s2),
        .s1(s1),
        .floor(floor),
        .moving(moving),
        .limit_fault(limit_fault)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge CCLK);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        motor = 2'b00;
        edges(2);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        motor    = 2'b00;
        #3;
        check("in_rst_sens", {s4, s3, s2, s1}, 4'b0001);
        check("in_rst_floor", floor, 2'd0);
        edges(2);
        rst = 1'b0;
        edges(1);
        check("rst_sens", {s4, s3, s2, s1}, 4'b0001);
        check("rst_floor", floor, 2'd0);
        check("rst_moving", moving, 1'b0);
        check("rst_fault", limit_fault, 1'b0);

`ifdef SHAFT_INERTIA_EN
        motor = 2'b01;
        edges(4);
        motor = 2'b00;
        edges(1);
        check("in4_sub", dut.sub_cnt, 3'd0);
        check("in4_moving", moving, 1'b0);
        motor = 2'b01;
        edges(5);
        check("in5_sub", dut.sub_cnt, 3'd0);
        check("in5_moving", moving, 1'b0);
        edges(1);
        check("in6_sub", dut.sub_cnt, 3'd1);
        check("in6_moving", moving, 1'b1);
        motor = 2'b00;
        edges(1);
        check("in_stop_sub", dut.sub_cnt, 3'd1);
        check("in_stop_moving", moving, 1'b0);
        check("in_floor", floor, 2'd0);
        check("in_fault", limit_fault, 1'b0);
`else
        motor = 2'b10;
        edges(1);
        check("bot_fault", limit_fault, 1'b1);
        check("bot_floor", floor, 2'd0);
        check("bot_sens", {s4, s3, s2, s1}, 4'b0001);
        check("bot_moving", moving, 1'b0);

        motor = 2'b01;
        edges(1);
        check("up1_sens", {s4, s3, s2, s1}, 4'b0001);
        check("up1_moving", moving, 1'b1);
        edges(1);
        check("up2_sens", {s4, s3, s2, s1}, 4'b0000);
        edges(3);
        check("up5_sens", {s4, s3, s2, s1}, 4'b0000);
        edges(1);
        check("up6_sens", {s4, s3, s2, s1}, 4'b0010);
        check("up6_floor", floor, 2'd0);
        edges(2);
        check("up8_floor", floor, 2'd1);
        check("up8_sens", {s4, s3, s2, s1}, 4'b0010);
        check("up8_sub", dut.sub_cnt, 3'd0);

        do_reset();
        edges(1);
        check("rst2_fault", limit_fault, 1'b0);
        motor = 2'b01;
        edges(12);
        check("mid_floor", floor, 2'd1);
        check("mid_sub", dut.sub_cnt, 3'd4);
        check("mid_sens", {s4, s3, s2, s1}, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        check("async_floor", floor, 2'd0);
        check("async_sens", {s4, s3, s2, s1}, 4'b0001);
        check("async_moving", moving, 1'b0);
        motor = 2'b00;
        edges(1);
        rst = 1'b0;

        motor = 2'b01;
        edges(24);
        check("top_floor", floor, 2'd3);
        check("top_sens", {s4, s3, s2, s1}, 4'b1000);
        check("top_fault0", limit_fault, 1'b0);
        edges(1);
        check("lim_fault", limit_fault, 1'b1);
        check("lim_floor", floor, 2'd3);
        check("lim_moving", moving, 1'b0);
        check("lim_sens", {s4, s3, s2, s1}, 4'b1000);
        edges(2);
        check("lim_hold_sub", dut.sub_cnt, 3'd0);
        check("lim_hold_floor", floor, 2'd3);
        motor = 2'b10;
        edges(1);
        check("dn_floor", floor, 2'd2);
        check("dn_sub", dut.sub_cnt, 3'd7);
        check("dn_sens", {s4, s3, s2, s1}, 4'b1000);
        check("dn_moving", moving, 1'b1);
        motor = 2'b11;
        edges(1);
        check("brk_moving", moving, 1'b0);
        check("brk_sub", dut.sub_cnt, 3'd7);
        check("brk_fault", limit_fault, 1'b1);
        motor = 2'b10;
        edges(2);
        check("dn2_sub", dut.sub_cnt, 3'd5);
        check("dn2_sens", {s4, s3, s2, s1}, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
